load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the shared memory bus.
- Takes one load or store request at a time, of byte, half-word or word size, at any byte address.
- Rejects misaligned accesses and places store data and byte strobes on the correct lanes.
- Runs a valid/ready bus transaction, then returns the load result (shifted and sign/zero-extended) or an error flag.
- Uses the team's word_t, wstrobe_t and byte_t types from Types_pkg.

Parameters:
- BUS_TIMEOUT, 255: maximum number of cycles bus_valid may stay high without bus_ready. Value 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_address  in  32 (word_t)  byte address.
- req_wdata  in  32 (word_t)  store data, right-aligned.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_rdata  out  32 (word_t)  extended load data; 0 for stores and errors.
- rsp_error  out  1  misaligned, illegal-size or timeout; valid with rsp_valid.
- bus_valid  out  1  bus request.
- bus_ready  in  1  bus completes the transfer this cycle.
- bus_address  out  32 (word_t)  req_address with bits [1:0] forced to 0.
- bus_wstrobe  out  4 (wstrobe_t)  byte enables; 0 for loads.
- bus_wdata  out  32 (word_t)  lane-replicated store data.
- bus_rdata  in  32 (word_t)  read data, sampled when bus_valid && bus_ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: state IDLE; rsp_valid, rsp_error, bus_valid, bus_wstrobe and timeout counter 0; rsp_rdata, bus_address and bus_wdata 0. req_ready is 0 while reset_n is low.
- Reset mid-operation: any transaction is abandoned at the next edge. bus_valid drops and no response is produced.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all request fields.
  - Illegal request goes to RESP with error; no bus cycle is issued.
  - Legal request goes to BUS.
  - Illegal means size 3, half with address[0] = 1, or word with address[1:0] != 0.
- BUS:
  - bus_valid = 1. bus_address, bus_wstrobe and bus_wdata are registered and held stable until the handshake.
  - Store strobes: byte 4'b0001 << a[1:0]; half 4'b0011 << a[1:0]; word 4'b1111.
  - bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
  - On bus_ready: capture bus_rdata, go to RESP with no error.
  - Timeout counter clears on entry to BUS and increments on each BUS cycle without bus_ready.
  - If BUS_TIMEOUT != 0 and the counter equals BUS_TIMEOUT-1 with no bus_ready, go to RESP with error. bus_valid is therefore high for exactly BUS_TIMEOUT cycles.
  - bus_ready in that final cycle still completes normally.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
  - req_ready = 0 in BUS and RESP.
- Load extraction:
  - Byte lane = rdata >> (8 × a[1:0]).
  - Byte: bits [7:0], extended from bit 7.
  - Half: bits [15:0], extended from bit 15.
  - Word: unchanged.
  - Sign extension unless req_unsigned.
- Latency: request accepted at edge N; bus_valid high from N+1. If bus_ready arrives at N+1, rsp_valid is high at N+2 and req_ready is high again at N+3. A misaligned request gives rsp_valid at N+1.

Test Plan:
- Word load: LW addr 0x100, bus_ready on first BUS cycle, bus_rdata 0xDEADBEEF -> bus_address 0x100, wstrobe 0, rsp_rdata 0xDEADBEEF, rsp_error 0, rsp_valid 2 cycles after accept.
- Byte loads: LB addr 0x203 with rdata 0x80FF0000 -> rsp_rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x202 -> 0xFFFF80FF.
- Stores:
  - SB addr 0x11 data 0x12345678 -> bus_address 0x10, wstrobe 0x2, wdata 0x78787878.
  - SH addr 0x12 -> wstrobe 0xC, wdata 0x56785678.
  - rsp_rdata 0 in both cases.
- Misaligned and illegal: LW addr 0x102, SH addr 0x1, size 3 -> no bus_valid, rsp_valid with rsp_error 1 one cycle after accept.
- Backpressure and timeout, BUS_TIMEOUT = 4:
  - bus_ready withheld -> bus_valid high exactly 4 cycles, signals stable, then rsp_error 1.
  - bus_ready in the 4th cycle -> normal completion, rsp_error 0.
- Reset mid-BUS: assert reset_n low during BUS with bus_ready low -> bus_valid 0 after next edge, no rsp_valid. After release, req_ready 1 and a new LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store at a time, runs a valid/ready bus
// transfer with lane steering, and returns extended load data or an error.

package Types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;
  typedef logic [7:0]  byte_t;
endpackage

module load_store_unit
  import Types_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_size,
  input  logic       req_unsigned,
  input  word_t      req_address,
  input  word_t      req_wdata,
  output logic       rsp_valid,
  output word_t      rsp_rdata,
  output logic       rsp_error,
  output logic       bus_valid,
  input  logic       bus_ready,
  output word_t      bus_address,
  output wstrobe_t   bus_wstrobe,
  output word_t      bus_wdata,
  input  word_t      bus_rdata
);

  localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam bit TIMEOUT_EN = (BUS_TIMEOUT != 32'sd0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             unsigned_q, unsigned_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  word_t            rsp_rdata_q, rsp_rdata_d;
  logic             bus_valid_q, bus_valid_d;
  word_t            bus_address_q, bus_address_d;
  wstrobe_t         bus_wstrobe_q, bus_wstrobe_d;
  word_t            bus_wdata_q, bus_wdata_d;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = a[0];
      2'd2:    bad = (a != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic wstrobe_t strobe_for(input logic [1:0] size, input logic [1:0] a);
    wstrobe_t s;
    case (size)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = 4'b0011 << a;
      2'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic word_t wdata_for(input logic [1:0] size, input word_t wdata);
    word_t w;
    case (size)
      2'd0:    w = {4{wdata[7:0]}};
      2'd1:    w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend by access size.
  function automatic word_t extract_load(input word_t rdata, input logic [1:0] size,
                                         input logic [1:0] lane, input logic uns);
    word_t shifted;
    byte_t b;
    word_t r;
    shifted = rdata >> {lane, 3'b000};
    b       = shifted[7:0];
    case (size)
      2'd0:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation for the request/bus/response sequence.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    bus_valid_d   = bus_valid_q;
    bus_address_d = bus_address_q;
    bus_wstrobe_d = bus_wstrobe_q;
    bus_wdata_d   = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          lane_d     = req_address[1:0];
          if (is_illegal(req_size, req_address[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d       = BUS;
            cnt_d         = '0;
            bus_valid_d   = 1'b1;
            bus_address_d = {req_address[31:2], 2'b00};
            bus_wstrobe_d = req_write ? strobe_for(req_size, req_address[1:0]) : 4'b0000;
            bus_wdata_d   = req_write ? wdata_for(req_size, req_wdata) : 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (bus_ready) begin
          state_d     = RESP;
          bus_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'h0000_0000
                                : extract_load(bus_rdata, size_q, lane_q, unsigned_q);
        end else if (TIMEOUT_EN && (cnt_q == CNT_W'(BUS_TIMEOUT - 1))) begin
          // Final allowed cycle passed without a handshake: give up on the bus.
          state_d     = RESP;
          bus_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
      lane_q        <= 2'd0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0000_0000;
      bus_valid_q   <= 1'b0;
      bus_address_q <= 32'h0000_0000;
      bus_wstrobe_q <= 4'b0000;
      bus_wdata_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
      bus_valid_q   <= bus_valid_d;
      bus_address_q <= bus_address_d;
      bus_wstrobe_q <= bus_wstrobe_d;
      bus_wdata_q   <= bus_wdata_d;
    end
  end

  assign req_ready   = reset_n & (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_valid   = bus_valid_q;
  assign bus_address = bus_address_q;
  assign bus_wstrobe = bus_wstrobe_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with BUS_TIMEOUT = 4.

module tb_load_store_unit;
  import Types_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_size;
  logic       req_unsigned;
  word_t      req_address;
  word_t      req_wdata;
  logic       rsp_valid;
  word_t      rsp_rdata;
  logic       rsp_error;
  logic       bus_valid;
  logic       bus_ready;
  word_t      bus_address;
  wstrobe_t   bus_wstrobe;
  word_t      bus_wdata;
  word_t      bus_rdata;

  int n_checks;
  int n_fail;

  load_store_unit #(.BUS_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_address  (bus_address),
    .bus_wstrobe  (bus_wstrobe),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request. ready_at is the BUS cycle index (0-based) in which
  // bus_ready is raised, or -1 to withhold it. Called at a falling edge.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input word_t addr, input word_t wdata,
                         input int ready_at, input word_t rdata,
                         input logic exp_err, input word_t exp_rd, input int exp_cycles,
                         input logic [3:0] exp_strb, input word_t exp_baddr,
                         input word_t exp_bwdata);
    int cyc;
    int bus_cnt;
    bit seen;
    check_value({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_address  = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    check_value({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    cyc     = 0;
    bus_cnt = 0;
    seen    = 1'b0;
    while (!seen && cyc < 20) begin
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (bus_valid) begin
          check_value({tag, ".bus_address"}, bus_address, exp_baddr);
          check_value({tag, ".bus_wstrobe"}, 32'(bus_wstrobe), 32'(exp_strb));
          if (wr) check_value({tag, ".bus_wdata"}, bus_wdata, exp_bwdata);
          bus_ready = (bus_cnt == ready_at);
          bus_rdata = bus_ready ? rdata : 32'hA5A5_A5A5;
          bus_cnt++;
        end
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rdata = 32'h5A5A_5A5A;
        cyc++;
      end
    end
    check_value({tag, ".rsp_seen"}, 32'(seen), 32'd1);
    check_value({tag, ".latency"}, 32'(cyc), 32'(exp_cycles));
    check_value({tag, ".bus_cycles"}, 32'(bus_cnt), 32'(exp_cycles));
    check_value({tag, ".rsp_error"}, 32'(rsp_error), 32'(exp_err));
    check_value({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
    check_value({tag, ".bus_valid_at_rsp"}, 32'(bus_valid), 32'd0);
    @(negedge clk);
    check_value({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check_value({tag, ".ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_address  = 32'h0;
    req_wdata    = 32'h0;
    bus_ready    = 1'b0;
    bus_rdata    = 32'h0;
    repeat (3) @(negedge clk);
    check_value("reset.req_ready", 32'(req_ready), 32'd0);
    check_value("reset.bus_valid", 32'(bus_valid), 32'd0);
    check_value("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("reset.rsp_error", 32'(rsp_error), 32'd0);
    check_value("reset.rsp_rdata", rsp_rdata, 32'h0);
    check_value("reset.bus_wstrobe", 32'(bus_wstrobe), 32'd0);
    check_value("reset.bus_address", bus_address, 32'h0);
    check_value("reset.bus_wdata", bus_wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    //      tag     wr    sz    uns   addr          wdata         rdy rdata         err   exp_rd        cyc strb     baddr         bwdata
    run_req("lw",   1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1, 4'h0, 32'h0000_0100, 32'h0);
    run_req("lb",   1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,        0, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 1, 4'h0, 32'h0000_0200, 32'h0);
    run_req("lbu",  1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,        0, 32'h80FF_0000, 1'b0, 32'h0000_0080, 1, 4'h0, 32'h0000_0200, 32'h0);
    run_req("lh",   1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,        0, 32'h80FF_0000, 1'b0, 32'hFFFF_80FF, 1, 4'h0, 32'h0000_0200, 32'h0);
    run_req("lhu",  1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0,        0, 32'h80FF_0000, 1'b0, 32'h0000_80FF, 1, 4'h0, 32'h0000_0200, 32'h0);
    run_req("lb1",  1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0,        1, 32'h1234_5678, 1'b0, 32'h0000_0056, 2, 4'h0, 32'h0000_0200, 32'h0);
    run_req("lh0",  1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0,        0, 32'h1234_8001, 1'b0, 32'hFFFF_8001, 1, 4'h0, 32'h0000_0200, 32'h0);
    run_req("sb",   1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1'b0, 32'h0,        1, 4'h2, 32'h0000_0010, 32'h7878_7878);
    run_req("sh",   1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1'b0, 32'h0,        1, 4'hC, 32'h0000_0010, 32'h5678_5678);
    run_req("sw",   1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 2, 32'hFFFF_FFFF, 1'b0, 32'h0,        3, 4'hF, 32'h0000_0020, 32'hCAFE_F00D);
    run_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,      0, 32'h0,         1'b1, 32'h0,        0, 4'h0, 32'h0,         32'h0);
    run_req("sh_mis", 1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0,      0, 32'h0,         1'b1, 32'h0,        0, 4'h0, 32'h0,         32'h0);
    run_req("size3",  1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0,      0, 32'h0,         1'b1, 32'h0,        0, 4'h0, 32'h0,         32'h0);
    run_req("tmo",  1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,       -1, 32'h0,         1'b1, 32'h0,        4, 4'h0, 32'h0000_0300, 32'h0);
    run_req("last", 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,        3, 32'h1122_3344, 1'b0, 32'h1122_3344, 4, 4'h0, 32'h0000_0300, 32'h0);
    run_req("sbtmo", 1'b1, 2'd0, 1'b0, 32'h0000_0403, 32'h0000_00AB, -1, 32'h0,      1'b1, 32'h0,        4, 4'h8, 32'h0000_0400, 32'hABAB_ABAB);

    // Abandon a transaction by resetting while the bus is stalled.
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_address = 32'h0000_0500;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_value("rst_mid.bus_valid_before", 32'(bus_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_value("rst_mid.bus_valid", 32'(bus_valid), 32'd0);
    check_value("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("rst_mid.req_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_value("rst_mid.rsp_after", 32'(rsp_valid), 32'd0);
    check_value("rst_mid.bus_after", 32'(bus_valid), 32'd0);
    run_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1, 4'h0, 32'h0000_0600, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
